rpn_evaluator: RTL and testbench

//  Postfix (RPN) evaluator; consumes the token stream emitted by the infix->postfix converter.
//  - Number tokens are pushed on an internal operand stack.
//  - Operator tokens pop two operands, compute, and push the result.
//  - '=' publishes the final value on a result handshake, then clears the stack for the next expression.

---
 rtl/rpn_evaluator.sv | 159 +++++++++++++++
 tb/tb_rpn_evaluator.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rpn_evaluator.sv
// Postfix (RPN) expression evaluator.
// Consumes number/operator tokens from the infix->postfix converter, keeps
// operands on an internal stack and publishes the value of each expression
// on a result handshake when the '=' token arrives.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for a token; the only state that samples in_stb
//   EXEC   | operands latched, write a op b back into slot top-1
//   RESULT | result_stb held until downstream raises result_ack
//   ACK    | one-cycle in_ack pulse, upstream drops in_stb meanwhile
module rpn_evaluator #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 20,
    parameter int SP_W  = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_stb,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_is_operator,
    output logic             in_ack,
    output logic             result_stb,
    output logic [WIDTH-1:0] result_data,
    output logic             result_error,
    input  logic             result_ack,
    output logic [SP_W-1:0]  stack_depth
);

    typedef enum logic [1:0] {IDLE, EXEC, RESULT, ACK} state_t;

    localparam logic [2:0] OP_MUL = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_EQ  = 3'b100;

    localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);
    localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
    localparam logic [SP_W-1:0] SP_TWO  = SP_W'(2);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] stack [DEPTH];
    logic [SP_W-1:0]  sp;
    logic [SP_W-1:0]  top_idx, sec_idx;
    logic             err_flag;
    logic [WIDTH-1:0] opa, opb;
    logic [2:0]       op_q;
    logic [2:0]       tok_op;
    logic             tok_arith;
    logic             arith_ok;
    logic [WIDTH-1:0] alu_r;

    assign stack_depth = sp;
    assign top_idx     = sp - SP_ONE;
    assign sec_idx     = sp - SP_TWO;
    assign tok_op      = in_data[2:0];
    assign tok_arith   = (tok_op == OP_MUL) || (tok_op == OP_ADD) || (tok_op == OP_SUB);
    // An operator is only executed with two operands and a clean expression.
    assign arith_ok    = tok_arith && (sp >= SP_TWO) && !err_flag;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and the arithmetic result used in EXEC.
    always_comb begin
        state_nxt = state;
        alu_r     = '0;
        case (op_q)
            OP_MUL:  alu_r = opa * opb;
            OP_ADD:  alu_r = opa + opb;
            OP_SUB:  alu_r = opa - opb;
            default: alu_r = '0;
        endcase
        case (state)
            IDLE: begin
                if (in_stb) begin
                    if (!in_is_operator)     state_nxt = ACK;
                    else if (arith_ok)       state_nxt = EXEC;
                    else if (tok_op == OP_EQ) state_nxt = RESULT;
                    else                     state_nxt = ACK;
                end
            end
            EXEC:    state_nxt = ACK;
            RESULT:  if (result_ack) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand stack, error flag and handshake outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sp           <= '0;
            err_flag     <= 1'b0;
            in_ack       <= 1'b0;
            result_stb   <= 1'b0;
            result_data  <= '0;
            result_error <= 1'b0;
            opa          <= '0;
            opb          <= '0;
            op_q         <= '0;
            for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_stb) begin
                        if (!in_is_operator) begin
                            in_ack <= 1'b1;
                            if (sp == SP_FULL) begin
                                err_flag <= 1'b1;
                            end else if (!err_flag) begin
                                stack[sp] <= in_data;
                                sp        <= sp + SP_ONE;
                            end
                        end else if (arith_ok) begin
                            opb  <= stack[top_idx];
                            opa  <= stack[sec_idx];
                            op_q <= tok_op;
                        end else if (tok_op == OP_EQ) begin
                            result_stb <= 1'b1;
                            if ((sp == SP_ONE) && !err_flag) begin
                                result_data  <= stack[top_idx];
                                result_error <= 1'b0;
                            end else begin
                                result_data  <= '0;
                                result_error <= 1'b1;
                            end
                        end else begin
                            // Operator lacking operands, sticky error, or unknown code.
                            err_flag <= 1'b1;
                            in_ack   <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    stack[sec_idx] <= alu_r;
                    sp             <= top_idx;
                    in_ack         <= 1'b1;
                end
                RESULT: begin
                    if (result_ack) begin
                        result_stb   <= 1'b0;
                        result_data  <= '0;
                        result_error <= 1'b0;
                        sp           <= '0;
                        err_flag     <= 1'b0;
                        in_ack       <= 1'b1;
                    end
                end
                ACK:     in_ack <= 1'b0;
                default: in_ack <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_evaluator.sv
// Randomized bench for rpn_evaluator against a queue-based postfix model.
module tb_rpn_evaluator;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_stb;
    logic [31:0] in_data;
    logic        in_is_operator;
    logic        in_ack;
    logic        result_stb;
    logic [31:0] result_data;
    logic        result_error;
    logic        result_ack;
    logic [4:0]  stack_depth;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] q[$];
    bit          m_err;

    rpn_evaluator #(.WIDTH(32), .DEPTH(20), .SP_W(5)) dut (
        .CLK(CLK), .RST(RST),
        .in_stb(in_stb), .in_data(in_data), .in_is_operator(in_is_operator),
        .in_ack(in_ack),
        .result_stb(result_stb), .result_data(result_data),
        .result_error(result_error), .result_ack(result_ack),
        .stack_depth(stack_depth)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else n_pass++;
    endtask

    // Drive one non-'=' token, wait (bounded) for its ack, check latency and pulse width.
    task automatic drive_tok(input logic is_op, input logic [31:0] d, input int exp_lat);
        int n;
        in_stb = 1'b1; in_is_operator = is_op; in_data = d;
        n = 0;
        do begin
            @(posedge CLK); #1; n++;
        end while (!in_ack && n < 20);
        in_stb = 1'b0;
        chk("ack_latency", n, exp_lat);
        @(posedge CLK); #1;
        chk("ack_pulse", {31'd0, in_ack}, 0);
        chk("depth", {27'd0, stack_depth}, q.size());
    endtask

    task automatic send_num(input logic [31:0] v);
        if (!m_err) begin
            if (q.size() == 20) m_err = 1;
            else q.push_back(v);
        end
        drive_tok(1'b0, v, 1);
    endtask

    task automatic send_op(input logic [2:0] code);
        logic [31:0] a, b, r;
        int lat;
        lat = 1;
        if (code >= 3'd1 && code <= 3'd3 && !m_err && q.size() >= 2) begin
            b = q.pop_back();
            a = q.pop_back();
            r = (code == 3'd1) ? a * b : (code == 3'd2) ? a + b : a - b;
            q.push_back(r);
            lat = 2;
        end else begin
            m_err = 1;
        end
        drive_tok(1'b1, {29'd0, code}, lat);
    endtask

    task automatic send_eq(input int hold);
        logic [31:0] ed;
        logic        ee;
        if (q.size() == 1 && !m_err) begin ed = q[0]; ee = 0; end
        else begin ed = 0; ee = 1; end
        in_stb = 1'b1; in_is_operator = 1'b1; in_data = 32'd4;
        @(posedge CLK); #1;
        chk("res_stb", {31'd0, result_stb}, 1);
        chk("res_data", result_data, ed);
        chk("res_err", {31'd0, result_error}, {31'd0, ee});
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); #1;
            chk("hold_stb", {31'd0, result_stb}, 1);
            chk("hold_data", result_data, ed);
            chk("hold_ack", {31'd0, in_ack}, 0);
        end
        result_ack = 1'b1;
        @(posedge CLK); #1;
        result_ack = 1'b0; in_stb = 1'b0;
        q.delete(); m_err = 0;
        chk("eq_ack", {31'd0, in_ack}, 1);
        chk("eq_stb_clr", {31'd0, result_stb}, 0);
        chk("eq_data_clr", result_data, 0);
        chk("eq_depth", {27'd0, stack_depth}, 0);
        @(posedge CLK); #1;
        chk("eq_ack_pulse", {31'd0, in_ack}, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"},   {31'd0, in_ack}, 0);
        chk({tag, "_stb"},   {31'd0, result_stb}, 0);
        chk({tag, "_data"},  result_data, 0);
        chk({tag, "_err"},   {31'd0, result_error}, 0);
        chk({tag, "_depth"}, {27'd0, stack_depth}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int r;
        int ntok;
        RST = 1'b1; in_stb = 1'b0; in_data = '0; in_is_operator = 1'b0; result_ack = 1'b0;
        m_err = 0;
        repeat (3) @(posedge CLK);
        #1;
        chk_all_zero("reset");
        RST = 1'b0;

        // 3 4 + 2 * = -> 14
        send_num(3); send_num(4); send_op(3'd2); send_num(2); send_op(3'd1);
        chk("model_14", q[0], 14);
        send_eq(1);
        // 5 9 - = -> -4
        send_num(5); send_num(9); send_op(3'd3); send_eq(0);
        // multiply wrap
        send_num(32'h0001_0000); send_num(32'h0001_0000); send_op(3'd1); send_eq(0);
        // empty-stack operator, then recovery
        send_op(3'd2); send_eq(0);
        send_num(7); send_eq(0);
        // overflow: 21 numbers
        for (int i = 0; i < 21; i++) send_num(i + 100);
        chk("full_depth", {27'd0, stack_depth}, 20);
        send_eq(0);
        // unknown operator
        send_num(1); send_op(3'b111); send_num(2); send_eq(0);
        // long hold
        send_num(55); send_eq(10);

        // reset while a result is pending
        send_num(9);
        in_stb = 1'b1; in_is_operator = 1'b1; in_data = 32'd4;
        @(posedge CLK); #1;
        chk("pre_rst_stb", {31'd0, result_stb}, 1);
        RST = 1'b1; in_stb = 1'b0;
        @(posedge CLK); #1;
        chk_all_zero("mid_rst");
        RST = 1'b0; q.delete(); m_err = 0;
        send_num(7); send_eq(0);

        // randomized expressions
        for (int e = 0; e < 40; e++) begin
            ntok = $urandom_range(1, 10);
            for (int t = 0; t < ntok; t++) begin
                r = $urandom_range(0, 99);
                if (r < 3) begin
                    case ($urandom_range(0, 3))
                        0: send_op(3'd0);
                        1: send_op(3'd5);
                        2: send_op(3'd6);
                        default: send_op(3'd7);
                    endcase
                end else if (r < 8 || (q.size() >= 2 && r < 50)) begin
                    send_op(3'($urandom_range(1, 3)));
                end else if (r < 75) begin
                    send_num($urandom_range(0, 20));
                end else begin
                    send_num($urandom);
                end
            end
            send_eq($urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
